// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared types and constants for the program-counter
//                sequencer: FSM state enum, next-PC select, opcode patterns,
//                program entry points and instruction ROM depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_BR = 3'd3,
        ST_HALTED  = 3'd4
    } state_e;

    // Next-PC operation selected for pc_next_calc
    typedef enum logic [1:0] {
        NPC_INC  = 2'd0,
        NPC_FWD  = 2'd1,
        NPC_BACK = 2'd2
    } npc_sel_e;

    // Opcodes: branch patterns compare only the bits set in OP_BR_CARE_MASK
    localparam logic [7:0] OP_HALT          = 8'b1000_1000;
    localparam logic [7:0] OP_BR_FWD_MASK   = 8'b1111_0000;
    localparam logic [7:0] OP_BR_BACK_MASK  = 8'b1011_0000;
    localparam logic [7:0] OP_BR_CARE_MASK  = 8'b1111_1000;

    // Program entry points
    localparam logic [7:0] ENTRY_MULT = 8'd0;
    localparam logic [7:0] ENTRY_STRM = 8'd93;
    localparam logic [7:0] ENTRY_PAIR = 8'd138;

    // Number of populated instruction ROM words
    localparam logic [7:0] ROM_DEPTH  = 8'd196;

    function automatic logic is_br_fwd(input logic [7:0] op);
        return (op & OP_BR_CARE_MASK) == OP_BR_FWD_MASK;
    endfunction

    function automatic logic is_br_back(input logic [7:0] op);
        return (op & OP_BR_CARE_MASK) == OP_BR_BACK_MASK;
    endfunction

    function automatic logic [7:0] entry_pc(input logic [1:0] sel);
        logic [7:0] pc;
        case (sel)
            2'd0:    pc = ENTRY_MULT;
            2'd1:    pc = ENTRY_STRM;
            2'd2:    pc = ENTRY_PAIR;
            default: pc = 8'd0;
        endcase
        return pc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_calc
//  Description : Combinational next-PC: increment, forward or backward
//                branch offset. All arithmetic wraps modulo 256.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [7:0] pc_i,
    input  logic [7:0] off_i,
    input  npc_sel_e   sel_i,
    output logic [7:0] pc_o
);

    // Select the next PC; 8-bit result truncation gives the modulo-256 wrap
    always_comb begin
        pc_o = pc_i + 8'd1;
        case (sel_i)
            NPC_FWD:  pc_o = pc_i + off_i;
            NPC_BACK: pc_o = pc_i - off_i;
            default:  pc_o = pc_i + 8'd1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer. Fetches from a combinational
//                instruction ROM, issues each instruction over a valid/ready
//                handshake, waits for branch resolution and stops on halt.
//                Optional feature macro PC_BOUNDS_CHECK_EN: fetching at or
//                beyond ROM_DEPTH raises a sticky fault and halts.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [1:0] prog_sel_i,
    output logic [7:0] inst_addr_o,
    input  logic [7:0] inst_data_i,
    output logic [7:0] inst_o,
    output logic       inst_valid_o,
    input  logic       inst_ready_i,
    input  logic       br_valid_i,
    input  logic       br_taken_i,
    input  logic [7:0] br_off_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] inst_q, inst_d;
    logic       done_q, done_d;
    npc_sel_e   npc_sel;
    logic [7:0] pc_next;

`ifdef PC_BOUNDS_CHECK_EN
    logic       fault_q, fault_d;
`endif

    pc_next_calc u_pc_next_calc (
        .pc_i  (pc_q),
        .off_i (br_off_i),
        .sel_i (npc_sel),
        .pc_o  (pc_next)
    );

    // Branch direction comes from the held instruction; anything else increments
    always_comb begin
        npc_sel = NPC_INC;
        if (state_q == ST_WAIT_BR && br_taken_i) begin
            npc_sel = is_br_fwd(inst_q) ? NPC_FWD : NPC_BACK;
        end
    end

    // FSM next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        done_d  = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start_i) begin
                    pc_d    = entry_pc(prog_sel_i);
`ifdef PC_BOUNDS_CHECK_EN
                    fault_d = 1'b0;
`endif
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
`ifdef PC_BOUNDS_CHECK_EN
                if (pc_q >= ROM_DEPTH) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_HALTED;
                end else
`endif
                begin
                    inst_d  = inst_data_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inst_ready_i) begin
                    if (inst_q == OP_HALT) begin
                        done_d  = 1'b1;
                        state_d = ST_HALTED;
                    end else if (is_br_fwd(inst_q) || is_br_back(inst_q)) begin
                        // PC stays on the branch until the datapath resolves it
                        state_d = ST_WAIT_BR;
                    end else begin
                        pc_d    = pc_next;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WAIT_BR: begin
                if (br_valid_i) begin
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'd0;
            inst_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    // Sticky fault flag, cleared only by reset or a new start
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    assign inst_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = (state_q == ST_ISSUE);
    assign busy_o       = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                          (state_q == ST_WAIT_BR);
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard bench for pc_sequencer. A program-level model
//                walks a randomised ROM image and queues the expected issued
//                (address, instruction) pairs; a negedge monitor pops and
//                compares each new issue and checks it stays stable while held.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] prog_sel_i = 2'd0;
    logic [7:0] inst_addr_o;
    logic [7:0] inst_data_i;
    logic [7:0] inst_o;
    logic       inst_valid_o;
    logic       inst_ready_i = 1'b0;
    logic       br_valid_i = 1'b0;
    logic       br_taken_i = 1'b0;
    logic [7:0] br_off_i = 8'd0;
    logic       busy_o;
    logic       done_o;
    logic       fault_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rom [256];
    logic [15:0] sb [$];     // expected {address, instruction} per issue
    logic [8:0]  fq [$];     // forced branch outcomes {taken, offset}

    always #5 clk_i = ~clk_i;

    assign inst_data_i = rom[inst_addr_o];

    pc_sequencer dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .start_i      (start_i),
        .prog_sel_i   (prog_sel_i),
        .inst_addr_o  (inst_addr_o),
        .inst_data_i  (inst_data_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .br_valid_i   (br_valid_i),
        .br_taken_i   (br_taken_i),
        .br_off_i     (br_off_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fault_o      (fault_o)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_halt(input logic [7:0] op);
        return op == 8'b1000_1000;
    endfunction

    function automatic bit is_fwd(input logic [7:0] op);
        return op[7:3] == 5'b11110;
    endfunction

    function automatic bit is_back(input logic [7:0] op);
        return op[7:3] == 5'b10110;
    endfunction

    function automatic logic [7:0] entry_of(input logic [1:0] sel);
        int e [4] = '{0, 93, 138, 0};
        return 8'(e[sel]);
    endfunction

    function automatic bit out_of_bounds(input logic [7:0] pc);
`ifdef PC_BOUNDS_CHECK_EN
        return int'(pc) >= 196;
`else
        return (pc != pc);
`endif
    endfunction

    function automatic logic [7:0] rand_op(input bit plain);
        logic [7:0] v;
        int r;
        r = $urandom_range(0, 99);
        if (!plain && r < 8) return 8'b1000_1000;
        if (!plain && r < 20) return {(($urandom_range(0, 1) == 1) ? 5'b11110 : 5'b10110), 3'($urandom)};
        do v = 8'($urandom); while (is_halt(v) || is_fwd(v) || is_back(v));
        return v;
    endfunction

    // Monitor: pop a new expectation on each fresh issue, check stability while held
    logic        mon_prev_valid = 1'b0;
    logic [15:0] mon_cur = 16'd0;
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            mon_prev_valid = 1'b0;
        end else begin
            if (inst_valid_o) begin
                chk1("valid_implies_busy", busy_o, 1'b1);
                if (!mon_prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got addr %0d inst %0h expected no issue", inst_addr_o, inst_o);
                    end else begin
                        mon_cur = sb.pop_front();
                        chk8("issue_addr", inst_addr_o, mon_cur[15:8]);
                        chk8("issue_inst", inst_o, mon_cur[7:0]);
                    end
                end else begin
                    chk8("hold_addr", inst_addr_o, mon_cur[15:8]);
                    chk8("hold_inst", inst_o, mon_cur[7:0]);
                end
            end
            mon_prev_valid = inst_valid_o;
        end
    end

    task automatic chk_quiet(input string tag);
        chk1({tag, "_busy"},  busy_o, 1'b0);
        chk1({tag, "_valid"}, inst_valid_o, 1'b0);
        chk1({tag, "_done"},  done_o, 1'b0);
        chk1({tag, "_fault"}, fault_o, 1'b0);
        chk8({tag, "_addr"},  inst_addr_o, 8'd0);
        chk8({tag, "_inst"},  inst_o, 8'd0);
    endtask

    task automatic do_reset();
        start_i      = 1'b0;
        inst_ready_i = 1'b0;
        br_valid_i   = 1'b0;
        reset_ni     = 1'b0;
        #1;
        chk_quiet("reset");
        step();
        reset_ni = 1'b1;
        sb.delete();
        repeat (3) step();
        chk_quiet("post_reset");
    endtask

    // Drive one program run; the model PC follows the spec rules on its own ROM copy
    task automatic run_program(input logic [1:0] sel, input int bound, input bit rst_in_wait,
                               output bit ended);
        logic [7:0] pc;
        logic [7:0] op;
        logic [8:0] f;
        logic [7:0] off;
        bit         taken;
        int         n;
        int         hold;
        ended      = 1'b0;
        prog_sel_i = sel;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        prog_sel_i = 2'($urandom);
        pc = entry_of(sel);
        n  = 0;
        forever begin
            chk8("fetch_addr", inst_addr_o, pc);
            chk1("fetch_busy", busy_o, 1'b1);
            chk1("fetch_valid", inst_valid_o, 1'b0);
            chk1("fetch_done", done_o, 1'b0);
            chk1("fetch_fault", fault_o, 1'b0);
            if (out_of_bounds(pc)) begin
                step();
                chk1("oob_done", done_o, 1'b1);
                chk1("oob_fault", fault_o, 1'b1);
                chk1("oob_busy", busy_o, 1'b0);
                chk1("oob_valid", inst_valid_o, 1'b0);
                step();
                chk1("oob_done_end", done_o, 1'b0);
                chk1("oob_fault_sticky", fault_o, 1'b1);
                ended = 1'b1;
                return;
            end
            if (n >= bound) return;
            sb.push_back({pc, rom[pc]});
            step();
            chk1("issue_latency", inst_valid_o, 1'b1);
            hold = (n == 0) ? 5 : int'($urandom_range(0, 3));
            repeat (hold) begin
                start_i    = ($urandom_range(0, 3) == 0);
                prog_sel_i = 2'($urandom);
                br_valid_i = ($urandom_range(0, 3) == 0);
                br_taken_i = 1'($urandom);
                br_off_i   = 8'($urandom);
                step();
            end
            start_i      = 1'b0;
            br_valid_i   = 1'b0;
            inst_ready_i = 1'b1;
            step();
            inst_ready_i = 1'b0;
            n++;
            op = rom[pc];
            if (is_halt(op)) begin
                chk1("halt_done", done_o, 1'b1);
                chk1("halt_busy", busy_o, 1'b0);
                chk1("halt_valid", inst_valid_o, 1'b0);
                step();
                chk1("halt_done_end", done_o, 1'b0);
                chk1("halt_busy_end", busy_o, 1'b0);
                ended = 1'b1;
                return;
            end else if (is_fwd(op) || is_back(op)) begin
                chk8("wait_addr", inst_addr_o, pc);
                chk1("wait_busy", busy_o, 1'b1);
                chk1("wait_valid", inst_valid_o, 1'b0);
                repeat ($urandom_range(0, 2)) begin
                    start_i    = ($urandom_range(0, 1) == 0);
                    prog_sel_i = 2'($urandom);
                    step();
                    chk8("wait_hold_addr", inst_addr_o, pc);
                end
                start_i = 1'b0;
                if (rst_in_wait) begin
                    #2;
                    reset_ni = 1'b0;
                    #1;
                    chk_quiet("async_reset");
                    br_valid_i = 1'b1;
                    br_taken_i = 1'b1;
                    br_off_i   = 8'd7;
                    step();
                    step();
                    reset_ni = 1'b1;
                    repeat (3) step();
                    chk_quiet("late_br");
                    br_valid_i = 1'b0;
                    sb.delete();
                    return;
                end
                if (fq.size() > 0) begin
                    f     = fq.pop_front();
                    taken = f[8];
                    off   = f[7:0];
                end else begin
                    taken = 1'($urandom);
                    off   = 8'($urandom);
                end
                br_valid_i = 1'b1;
                br_taken_i = taken;
                br_off_i   = off;
                step();
                br_valid_i = 1'b0;
                br_taken_i = 1'($urandom);
                br_off_i   = 8'($urandom);
                if (!taken)          pc = 8'((int'(pc) + 1) % 256);
                else if (is_fwd(op)) pc = 8'((int'(pc) + int'(off)) % 256);
                else                 pc = 8'((int'(pc) - int'(off) + 256) % 256);
            end else begin
                pc = 8'((int'(pc) + 1) % 256);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ended;
        for (int a = 0; a < 196; a++) rom[a] = rand_op(1'b0);
        for (int a = 196; a < 256; a++) rom[a] = 8'hFF;
        for (int a = 3; a < 17; a++) rom[a] = rand_op(1'b1);
        for (int a = 190; a < 196; a++) rom[a] = rand_op(1'b1);
        rom[0]   = 8'b1111_0011;
        rom[1]   = 8'b1000_1000;
        rom[2]   = 8'b1011_0101;
        rom[17]  = 8'b1111_0001;
        rom[18]  = 8'b1000_1000;
        rom[23]  = 8'b1111_0010;
        rom[29]  = 8'b1000_1000;
        rom[47]  = 8'b1011_0100;
        rom[92]  = 8'b1000_1000;
        rom[93]  = 8'b1011_0001;
        rom[138] = 8'b1111_0110;

        step();
        do_reset();

        // string match entry: 93 branches back by 1 onto the halt at 92
        fq = {9'h101};
        run_program(2'd1, 200, 1'b0, ended);
        // restart from HALTED at 138, jump to 190 and run past the ROM end
        fq = {9'h134, 9'h000};
        run_program(2'd2, 200, 1'b0, ended);
        if (!ended) do_reset();
        // 0 -> 17 -> 23 -> 47 -> 29 (halt)
        fq = {9'h111, 9'h106, 9'h118, 9'h112};
        run_program(2'd0, 200, 1'b0, ended);
        if (!ended) do_reset();
        // branch at 17 not taken -> 18 (halt)
        fq = {9'h111, 9'h000};
        run_program(2'd3, 200, 1'b0, ended);
        if (!ended) do_reset();
        // 0 -> 2, back by 5 wraps to 253, then 255 + 1 wraps to 0
        fq = {9'h102, 9'h105, 9'h000};
        run_program(2'd0, 200, 1'b0, ended);
        if (!ended) do_reset();
        // reset while waiting on the branch at 93
        fq.delete();
        run_program(2'd1, 200, 1'b1, ended);

        for (int r = 0; r < 10; r++) begin
            fq.delete();
            run_program(2'($urandom), 40, 1'b0, ended);
            if (!ended || $urandom_range(0, 3) == 0) do_reset();
        end

        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_ni, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, a pulse that launches the program selected by prog_sel_i.
REQ-004 SHALL have port prog_sel_i, input, 2, entry select: 0 -> 0 (multiply), 1 -> 93 (string match), 2 -> 138 (closest pair), 3 -> 0.
REQ-005 SHALL have port inst_addr_o, output, 8, the PC driven to the instruction ROM address.
REQ-006 SHALL have port inst_data_i, input, 8, the combinational ROM data for inst_addr_o.
REQ-007 SHALL have port inst_o, output, 8, the registered instruction presented to the datapath.
REQ-008 SHALL have ports inst_valid_o (output, 1) and inst_ready_i (input, 1), the issue handshake.
REQ-009 SHALL have ports br_valid_i (1), br_taken_i (1) and br_off_i (8), all inputs, carrying the datapath's branch resolution.
REQ-010 SHALL have outputs busy_o (1), done_o (1, one-cycle pulse) and fault_o (1, sticky).

Function
REQ-011 SHALL implement the states IDLE, FETCH, ISSUE, WAIT_BR and HALTED.
REQ-012 IDLE/HALTED + start_i: pc <= entry(prog_sel_i), fault_o cleared, next state FETCH; start_i SHALL be ignored in every other state.
REQ-013 FETCH SHALL last exactly 1 cycle: inst_o <= inst_data_i, next state ISSUE.
REQ-014 ISSUE SHALL hold inst_valid_o=1 with inst_o stable until inst_ready_i=1; transfer occurs on the cycle both are high.
REQ-015 On transfer of halt (8'b10001000), SHALL go to HALTED and pulse done_o in the first HALTED cycle.
REQ-016 On transfer of a branch (fwd 8'b11110xxx, back 8'b10110xxx), SHALL go to WAIT_BR and hold pc at the branch address.
REQ-017 On transfer of any other opcode, SHALL set pc <= pc+1 and go to FETCH; issue latency from transfer to the next inst_valid_o SHALL be 2 cycles.
REQ-018 WAIT_BR + br_valid_i: if taken, pc <= pc+br_off_i (forward) or pc-br_off_i (backward); otherwise pc <= pc+1; next state FETCH.
REQ-019 br_valid_i outside WAIT_BR SHALL be ignored.
REQ-020 All PC arithmetic SHALL be modulo 256 (255+1 -> 0; 2-5 -> 253).
REQ-021 busy_o SHALL be 1 in FETCH, ISSUE and WAIT_BR, and 0 otherwise.
REQ-022 inst_valid_o SHALL be 1 only in ISSUE.

Reset
REQ-023 reset_ni low SHALL immediately force state IDLE, pc=0, inst_o=0 and all flags=0, aborting any in-flight fetch, issue or branch wait.
REQ-024 After reset release, no output SHALL change until start_i.

Configuration
REQ-025 With PC_BOUNDS_CHECK_EN defined: in FETCH, if pc >= ROM_DEPTH (196), SHALL set fault_o, skip ISSUE, go to HALTED, and pulse done_o.
REQ-026 Without PC_BOUNDS_CHECK_EN: no check is made, any pc is fetched, fault_o is tied 0, and ROM default 8'hFF is issued as data.

Structure
REQ-027 A shared package SHALL hold: the state enum, opcode constants OP_HALT, OP_BR_FWD_MASK and OP_BR_BACK_MASK, the ENTRY_MULT/ENTRY_STRM/ENTRY_PAIR constants, and ROM_DEPTH.
REQ-028 A sub-module pc_next_calc SHALL compute the combinational next-PC (inc/fwd/back, mod 256).

Verification
REQ-029 Reset then start_i with prog_sel_i=1 -> inst_addr_o=93 next cycle, inst_valid_o one cycle later with inst_o=ROM[93].
REQ-030 inst_ready_i held low 5 cycles in ISSUE -> inst_o and inst_valid_o stable, pc unchanged, no skipped address.
REQ-031 Branch at pc=17, br_taken_i=1, br_off_i=6 -> next fetch address 23; with br_taken_i=0 -> 18; branch-back at 47 with off 18 -> 29.
REQ-032 Halt at pc=92 -> done_o single pulse, busy_o=0; a later start_i with prog_sel_i=2 restarts at 138.
REQ-033 reset_ni asserted in WAIT_BR -> IDLE asynchronously; the late br_valid_i is ignored.
REQ-034 PC_BOUNDS_CHECK_EN: run past 195 -> fault_o=1 at pc=196, no issue; without the macro, 8'hFF is issued.
